lfo_ctrl: RTL and testbench



---
 rtl/lfo_ctrl.sv | 135 +++++++++++++
 tb/tb_lfo_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lfo_ctrl.sv
// Sequencer for LFOgen: free-running sample strobe, zero-crossing freq commit,
// and one-LSB-per-step scale ramping so parameter changes never glitch the wave.
module lfo_ctrl #(
    parameter int CYCLES_PER_TICK = 136,
    parameter int RAMP_SAMPLES    = 64,
    parameter int XING_TIMEOUT    = 4096
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [3:0]  freqReq_i,
    input  logic [3:0]  scaleReq_i,
    input  logic [15:0] waveIn_i,
    input  logic        newVal_i,
    output logic        FIFOupdate_o,
    output logic [3:0]  freqSetting_o,
    output logic [3:0]  scaleFactor_o,
    output logic        busy_o
);

    localparam int TW  = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam int RW  = $clog2(RAMP_SAMPLES + 1);
    localparam int TOW = $clog2(XING_TIMEOUT + 1);

    localparam logic [TW-1:0]  TICK_LAST = TW'(CYCLES_PER_TICK - 1);
    localparam logic [RW-1:0]  RAMP_LAST = RW'(RAMP_SAMPLES - 1);
    localparam logic [TOW-1:0] TOUT_LAST = TOW'(XING_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_XING = 2'd1,
        RAMP      = 2'd2
    } state_t;

    state_t         state;
    logic [TW-1:0]  tick_cnt;
    logic [RW-1:0]  ramp_cnt;
    logic [TOW-1:0] tout_cnt;
    logic [3:0]     freq_tgt;
    logic [3:0]     scale_tgt;
    logic           prev_sign;
    logic           xing;
    logic           timeout_hit;
    logic           flat;
    logic [3:0]     scale_step;

    // Sample strobe: free-running, independent of the sequencer state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tick_cnt     <= '0;
            FIFOupdate_o <= 1'b0;
        end else begin
            FIFOupdate_o <= (tick_cnt == TICK_LAST);
            tick_cnt     <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            freq_tgt  <= '0;
            scale_tgt <= '0;
            prev_sign <= 1'b0;
        end else begin
            freq_tgt  <= freqReq_i;
            scale_tgt <= scaleReq_i;
            if (newVal_i)
                prev_sign <= waveIn_i[15];
        end
    end

    // An exact zero sample counts as a crossing even without a sign change.
    assign xing        = newVal_i & ((waveIn_i[15] != prev_sign) | (waveIn_i == '0));
    assign timeout_hit = FIFOupdate_o & (tout_cnt == TOUT_LAST);
    assign flat        = (scaleFactor_o == 4'd0);

    always_comb begin
        scale_step = scaleFactor_o;
        if (scale_tgt > scaleFactor_o && scaleFactor_o != 4'hF)
            scale_step = scaleFactor_o + 4'd1;
        else if (scale_tgt < scaleFactor_o && scaleFactor_o != 4'h0)
            scale_step = scaleFactor_o - 4'd1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state         <= IDLE;
            ramp_cnt      <= '0;
            tout_cnt      <= '0;
            freqSetting_o <= '0;
            scaleFactor_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (freq_tgt != freqSetting_o) begin
                        state    <= WAIT_XING;
                        tout_cnt <= '0;
                    end else if (scale_tgt != scaleFactor_o) begin
                        state    <= RAMP;
                        ramp_cnt <= '0;
                    end
                end
                WAIT_XING: begin
                    if (freq_tgt == freqSetting_o) begin
                        state <= IDLE;
                    end else if (xing || timeout_hit || flat) begin
                        freqSetting_o <= freq_tgt;
                        state         <= IDLE;
                    end else if (FIFOupdate_o) begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end
                RAMP: begin
                    // A pending freq change pre-empts the ramp; it resumes via IDLE.
                    if (freq_tgt != freqSetting_o) begin
                        state    <= WAIT_XING;
                        tout_cnt <= '0;
                        ramp_cnt <= '0;
                    end else if (scale_tgt == scaleFactor_o) begin
                        state <= IDLE;
                    end else if (FIFOupdate_o) begin
                        if (ramp_cnt == RAMP_LAST) begin
                            scaleFactor_o <= scale_step;
                            ramp_cnt      <= '0;
                        end else begin
                            ramp_cnt <= ramp_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_lfo_ctrl.sv
// Directed bench for lfo_ctrl: strobe timing, scale ramp, crossing/timeout
// freq commits, freq-during-ramp pre-emption and mid-operation reset.
module tb_lfo_ctrl;
    localparam int CPT = 136;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  freq_req = '0;
    logic [3:0]  scale_req = '0;
    logic [15:0] wave = '0;
    logic        new_val = 1'b0;
    logic        strobe;
    logic [3:0]  freq;
    logic [3:0]  scale;
    logic        busy;

    int n_checks = 0;
    int n_err = 0;
    int cyc;

    lfo_ctrl #(.CYCLES_PER_TICK(CPT), .RAMP_SAMPLES(4), .XING_TIMEOUT(8)) dut (
        .clk_i(clk), .reset_ni(rst_n), .freqReq_i(freq_req), .scaleReq_i(scale_req),
        .waveIn_i(wave), .newVal_i(new_val), .FIFOupdate_o(strobe),
        .freqSetting_o(freq), .scaleFactor_o(scale), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Clocks elapsed since reset release; strobe expected on every CPT-th.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    always @(negedge clk)
        chk("strobe", int'(strobe), int'(cyc != 0 && cyc % CPT == 0));

    task automatic wait_strobe();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!strobe && n < 300);
        if (!strobe) chk("strobe_timeout", 0, 1);
    endtask

    task automatic pulse(input logic [15:0] v);
        wave = v;
        new_val = 1'b1;
        @(negedge clk);
        new_val = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset and strobe timing
        repeat (5) @(negedge clk);
        chk("rst_strobe", strobe, 0);
        chk("rst_freq", freq, 0);
        chk("rst_scale", scale, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (CPT - 1) @(negedge clk);
        chk("t1_pre_strobe", strobe, 0);
        @(negedge clk);
        chk("t1_first_strobe", strobe, 1);
        chk("t1_busy", busy, 0);

        // T2: scale ramp 0 -> 15, one step every 4 strobes
        scale_req = 4'd15;
        repeat (2) @(negedge clk);
        chk("t2_busy_start", busy, 1);
        for (int k = 1; k <= 60; k++) begin
            wait_strobe();
            @(negedge clk);
            chk($sformatf("t2_scale_%0d", k), scale, k / 4);
        end
        chk("t2_busy_end", busy, 1);
        @(negedge clk);
        chk("t2_idle", busy, 0);

        // T3: freq commit at crossing
        freq_req = 4'd3;
        wave = '0;
        repeat (3) @(negedge clk);
        chk("t3_no_early", freq, 0);
        pulse(16'd0);
        chk("t3_setup", freq, 3);
        @(negedge clk);
        freq_req = 4'd13;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            pulse(16'd500 + 16'(i));
            chk($sformatf("t3_hold_%0d", i), freq, 3);
            repeat (2) @(negedge clk);
        end
        pulse(-16'sd1000);
        chk("t3_commit", freq, 13);
        @(negedge clk);
        chk("t3_idle", busy, 0);

        // T4: timeout commit on the 8th strobe
        freq_req = 4'd3;
        repeat (3) @(negedge clk);
        pulse(16'd0);
        chk("t4_setup", freq, 3);
        pulse(16'd1000);
        wait_strobe();
        freq_req = 4'd4;
        for (int k = 1; k <= 8; k++) begin
            wait_strobe();
            @(negedge clk);
            chk($sformatf("t4_strobe_%0d", k), freq, (k == 8) ? 4 : 3);
        end

        // T6: reset mid-ramp
        scale_req = 4'd0;
        for (int k = 0; k < 40 && scale != 4'd7; k++) begin
            wait_strobe();
            @(negedge clk);
        end
        chk("t6_scale7", scale, 7);
        chk("t6_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        freq_req = 4'd0;
        #1;
        chk("t6_async_freq", freq, 0);
        chk("t6_async_scale", scale, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_strobe", strobe, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPT - 1) @(negedge clk);
        chk("t6_pre_strobe", strobe, 0);
        @(negedge clk);
        chk("t6_first_strobe", strobe, 1);

        // T5: flat-wave immediate commit, then freq change pre-empting a ramp
        freq_req = 4'd3;
        repeat (2) @(negedge clk);
        chk("t5_flat_pre", freq, 0);
        @(negedge clk);
        chk("t5_flat_commit", freq, 3);
        @(negedge clk);
        wait_strobe();
        scale_req = 4'd15;
        for (int k = 0; k < 30 && scale != 4'd5; k++) begin
            wait_strobe();
            @(negedge clk);
        end
        chk("t5_scale5", scale, 5);
        freq_req = 4'd13;
        wave = 16'd1000;
        for (int k = 0; k < 5; k++) begin
            wait_strobe();
            @(negedge clk);
            chk($sformatf("t5_hold_scale_%0d", k), scale, 5);
            chk($sformatf("t5_hold_freq_%0d", k), freq, 3);
        end
        chk("t5_busy", busy, 1);
        pulse(-16'sd1000);
        chk("t5_commit", freq, 13);
        for (int k = 1; k <= 4; k++) begin
            wait_strobe();
            @(negedge clk);
            chk($sformatf("t5_resume_%0d", k), scale, (k == 4) ? 6 : 5);
        end
        for (int k = 0; k < 50 && scale != 4'd15; k++) begin
            wait_strobe();
            @(negedge clk);
        end
        chk("t5_scale15", scale, 15);
        chk("t5_freq_final", freq, 13);
        repeat (2) @(negedge clk);
        chk("t5_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
